// File: rtl/if_stage_pipe.sv
// ============================================================================
// if_stage_pipe -- pipelined instruction-fetch stage
//
// Owns the PC, drives a synchronous instruction SRAM (1-cycle read latency)
// and presents {fs_pc, fs_inst} to decode over a valid/allowin handshake.
// Branch redirects from decode kill the wrong-path instruction held in IF.
// A redirect that arrives while IF cannot accept is remembered (br_pend)
// and fetched at the first cycle IF can accept again.
//
// Optional build macro:
//   IF_INST_BUF_EN  - add a one-entry instruction buffer that captures the
//                     SRAM read data on the first stalled cycle, for SRAMs
//                     that do not hold rdata while en=0. When undefined,
//                     fs_inst comes straight from the SRAM.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   inst_sram_en      SRAM read enable
//   inst_sram_we      SRAM byte write enables (tied 0)
//   inst_sram_addr    SRAM address (= nextpc)
//   inst_sram_wdata   SRAM write data (tied 0)
//   inst_sram_rdata   SRAM read data, valid the cycle after en
//   ds_allowin        decode can accept this cycle
//   br_taken          redirect request (1-cycle pulse)
//   br_target         redirect address
//   fs_to_ds_valid    {fs_pc, fs_inst} valid for decode
//   fs_pc             PC of the instruction held in IF
//   fs_inst           instruction held in IF
// ============================================================================
module if_stage_pipe #(
   parameter int              PC_W     = 32,
   parameter int              INST_W   = 32,
   parameter logic [PC_W-1:0] RESET_PC = 32'h1c000000
) (
   input  logic              clk,
   input  logic              reset,
   output logic              inst_sram_en,
   output logic [3:0]        inst_sram_we,
   output logic [PC_W-1:0]   inst_sram_addr,
   output logic [INST_W-1:0] inst_sram_wdata,
   input  logic [INST_W-1:0] inst_sram_rdata,
   input  logic              ds_allowin,
   input  logic              br_taken,
   input  logic [PC_W-1:0]   br_target,
   output logic              fs_to_ds_valid,
   output logic [PC_W-1:0]   fs_pc,
   output logic [INST_W-1:0] fs_inst
);

   logic            fs_valid;
   logic            fs_ready_go;
   logic            fs_allowin;
   logic            to_fs_valid;
   logic            br_pend;
   logic [PC_W-1:0] br_pend_target;
   logic [PC_W-1:0] nextpc;

   // ---------------------------------------------------------------- pre-IF
   assign to_fs_valid = ~reset;

   // A live redirect beats a remembered one; otherwise fall through.
   always_comb begin
      nextpc = fs_pc + PC_W'(4);
      if (br_taken)
         nextpc = br_target;
      else if (br_pend)
         nextpc = br_pend_target;
   end

   // ------------------------------------------------------------- handshake
   assign fs_ready_go    = 1'b1;
   assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
   // The instruction in IF is wrong-path whenever a redirect is asserted.
   assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken;

   assign inst_sram_en    = to_fs_valid & fs_allowin;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_we    = 4'b0;
   assign inst_sram_wdata = '0;

   // ------------------------------------------------------------- IF state
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid       <= 1'b0;
         fs_pc          <= RESET_PC - PC_W'(4);
         br_pend        <= 1'b0;
         br_pend_target <= '0;
      end else begin
         if (to_fs_valid && fs_allowin) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
         end else if (br_taken) begin
            // IF is full and stalled: drop the wrong-path instruction.
            fs_valid <= 1'b0;
         end

         // Any accept consumes a pending target (or fetches a live one
         // directly); a redirect that cannot be fetched now is remembered,
         // newest target winning.
         if (fs_allowin) begin
            br_pend <= 1'b0;
         end else if (br_taken) begin
            br_pend        <= 1'b1;
            br_pend_target <= br_target;
         end
      end
   end

   // ---------------------------------------------------- instruction output
`ifdef IF_INST_BUF_EN
   logic              buf_valid;
   logic [INST_W-1:0] inst_buf;

   // The SRAM word is valid only on the first stalled cycle; hold it here
   // until the instruction leaves IF or is killed.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
      end else if ((fs_to_ds_valid && ds_allowin) || br_taken) begin
         buf_valid <= 1'b0;
      end else if (fs_valid && !ds_allowin && !buf_valid) begin
         buf_valid <= 1'b1;
         inst_buf  <= inst_sram_rdata;
      end
   end

   assign fs_inst = buf_valid ? inst_buf : inst_sram_rdata;
`else
   // SRAM holds rdata while en=0, so a stall keeps fs_inst stable.
   assign fs_inst = inst_sram_rdata;
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
module tb_if_stage_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata = 32'h0;
   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   if_stage_pipe dut (
      .clk            (clk),
      .reset          (reset),
      .inst_sram_en   (inst_sram_en),
      .inst_sram_we   (inst_sram_we),
      .inst_sram_addr (inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata),
      .ds_allowin     (ds_allowin),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .fs_to_ds_valid (fs_to_ds_valid),
      .fs_pc          (fs_pc),
      .fs_inst        (fs_inst)
   );

   // Memory content is a fixed function of the address.
   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
   endfunction

   // SRAM model: 1-cycle read latency. With the buffer option built in,
   // the model garbles rdata whenever en=0 to prove the buffer is used.
   always @(posedge clk) begin
      if (inst_sram_en)
         inst_sram_rdata <= word(inst_sram_addr);
`ifdef IF_INST_BUF_EN
      else
         inst_sram_rdata <= ~inst_sram_rdata ^ 32'h0f0f_1234;
`endif
   end

   // Decode-side record of every transferred instruction.
   logic [31:0] got_pc[$];
   logic [31:0] got_inst[$];
   always @(posedge clk) begin
      if (fs_to_ds_valid && ds_allowin) begin
         got_pc.push_back(fs_pc);
         got_inst.push_back(fs_inst);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_pc[8];

   initial begin
      reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid", 32'(fs_to_ds_valid), 32'd0);
      chk("rst_en",    32'(inst_sram_en),   32'd0);
      chk("rst_we",    32'(inst_sram_we),   32'd0);
      chk("rst_wdata", inst_sram_wdata,     32'h0);
      chk("rst_pc",    fs_pc,               32'h1bfffffc);

      // C0: first fetch right after reset release
      #1; reset = 1'b0; #1;
      chk("c0_addr",  inst_sram_addr, 32'h1c000000);
      chk("c0_en",    32'(inst_sram_en), 32'd1);
      chk("c0_valid", 32'(fs_to_ds_valid), 32'd0);
      step(); #1;                                            // C1
      chk("c1_valid", 32'(fs_to_ds_valid), 32'd1);
      chk("c1_pc",    fs_pc, 32'h1c000000);
      chk("c1_inst",  fs_inst, word(32'h1c000000));
      chk("c1_addr",  inst_sram_addr, 32'h1c000004);
      step(); #1;                                            // C2
      chk("c2_addr",  inst_sram_addr, 32'h1c000008);

      // C3..C5: decode stalls with 1c000008 in IF
      step(); ds_allowin = 1'b0; #1;
      for (int i = 3; i <= 5; i++) begin
         if (i > 3) begin step(); #1; end
         chk($sformatf("stall%0d_pc", i),   fs_pc, 32'h1c000008);
         chk($sformatf("stall%0d_inst", i), fs_inst, word(32'h1c000008));
         chk($sformatf("stall%0d_en", i),   32'(inst_sram_en), 32'd0);
      end
      step(); ds_allowin = 1'b1; #1;                         // C6
      chk("c6_addr", inst_sram_addr, 32'h1c00000c);
      chk("c6_en",   32'(inst_sram_en), 32'd1);
      step(); #1;                                            // C7
      chk("c7_pc", fs_pc, 32'h1c00000c);

      // C8: redirect without stall while fs_pc=1c000010
      step(); br_taken = 1'b1; br_target = 32'h1c000100; #1;
      chk("c8_pc",    fs_pc, 32'h1c000010);
      chk("c8_valid", 32'(fs_to_ds_valid), 32'd0);
      chk("c8_addr",  inst_sram_addr, 32'h1c000100);
      step(); br_taken = 1'b0; #1;                           // C9
      chk("c9_pc",    fs_pc, 32'h1c000100);
      chk("c9_valid", 32'(fs_to_ds_valid), 32'd1);
      chk("c9_inst",  fs_inst, word(32'h1c000100));

      // C10: redirect while decode stalls
      step(); ds_allowin = 1'b0; br_taken = 1'b1; br_target = 32'h1c000200; #1;
      chk("c10_pc",    fs_pc, 32'h1c000104);
      chk("c10_valid", 32'(fs_to_ds_valid), 32'd0);
      chk("c10_en",    32'(inst_sram_en), 32'd0);
      step(); br_taken = 1'b0; #1;                           // C11
      chk("c11_valid", 32'(fs_to_ds_valid), 32'd0);
      chk("c11_en",    32'(inst_sram_en), 32'd1);
      chk("c11_addr",  inst_sram_addr, 32'h1c000200);
      step(); #1;                                            // C12
      chk("c12_pc", fs_pc, 32'h1c000200);
      chk("c12_en", 32'(inst_sram_en), 32'd0);
      step(); ds_allowin = 1'b1; #1;                         // C13
      chk("c13_pc",   fs_pc, 32'h1c000200);
      chk("c13_inst", fs_inst, word(32'h1c000200));
      chk("c13_addr", inst_sram_addr, 32'h1c000204);

      // C14: stalled redirect leaves br_pend=1, then reset in C15
      step(); ds_allowin = 1'b0; br_taken = 1'b1; br_target = 32'h1c000300; #1;
      step(); br_taken = 1'b0; reset = 1'b1; #1;             // C15
      chk("c15_en", 32'(inst_sram_en), 32'd0);
      step(); reset = 1'b0; ds_allowin = 1'b1; #1;           // C16
      chk("c16_valid", 32'(fs_to_ds_valid), 32'd0);
      chk("c16_addr",  inst_sram_addr, 32'h1c000000);
      chk("c16_en",    32'(inst_sram_en), 32'd1);
      step(); #1;                                            // C17
      chk("c17_pc", fs_pc, 32'h1c000000);

      // C18..C21: 4-cycle stall, fs_inst must stay the word at fs_pc
      step(); ds_allowin = 1'b0; #1;
      for (int i = 18; i <= 21; i++) begin
         if (i > 18) begin step(); #1; end
         chk($sformatf("bstall%0d_pc", i),   fs_pc, 32'h1c000004);
         chk($sformatf("bstall%0d_inst", i), fs_inst, word(32'h1c000004));
      end
      step(); ds_allowin = 1'b1; #1;                         // C22
      chk("c22_inst", fs_inst, word(32'h1c000004));
      chk("c22_addr", inst_sram_addr, 32'h1c000008);
      step(); #1;                                            // C23
      chk("c23_pc",   fs_pc, 32'h1c000008);
      chk("c23_inst", fs_inst, word(32'h1c000008));

      // Decode saw each right-path PC exactly once, in order.
      exp_pc = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c00000c,
                 32'h1c000100, 32'h1c000200, 32'h1c000000, 32'h1c000004};
      chk("ds_count", 32'(got_pc.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_pc.size()) begin
            chk($sformatf("ds_pc%0d", i),   got_pc[i],   exp_pc[i]);
            chk($sformatf("ds_inst%0d", i), got_inst[i], word(exp_pc[i]));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
